regfile_write_arbiter: RTL and testbench
========================================

Name: regfile_write_arbiter

Overview:
- Shares the single write port of the 32x32 register file between NUM_REQ writeback sources (e.g. ALU, load unit, mul/div).
- Keeps a scoreboard of destination registers with an in-flight producer.
- Gives decode RAW busy flags and a WAW issue stall.
- Sits between the execute/writeback units and the register file write port; the write port output is registered.

Parameters:
NUM_REQ, 3, number of writeback requesters (2..8)
XLEN, 32, data width
PTR_W, 3, width of round-robin pointer; must satisfy 2^PTR_W >= NUM_REQ

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
req_valid  input  NUM_REQ  requester i has a write pending
req_ready  output  NUM_REQ  requester i granted this cycle (combinational, one-hot or zero)
req_rd  input  5*NUM_REQ  destination register of requester i, bits [5i+4:5i]
req_data  input  XLEN*NUM_REQ  write data of requester i, bits [XLEN*i+XLEN-1:XLEN*i]
issue_valid  input  1  decode issues an instruction that writes issue_rd
issue_rd  input  5  destination of issuing instruction
issue_ready  output  1  issue may proceed (no WAW on issue_rd)
rs1_addr  input  5  decode source 1
rs2_addr  input  5  decode source 2
rs1_busy  output  1  rs1 has in-flight producer
rs2_busy  output  1  rs2 has in-flight producer
rf_write_enable  output  1  to register file write_enable
rf_write_reg  output  5  to register file write_reg
rf_write_data  output  XLEN  to register file write_data

Behaviour:
Clock and reset:
- Single clock clk.
- reset is asynchronous and active-high.
- Reset values:
  - rf_write_enable=0, rf_write_reg=0, rf_write_data=0.
  - All scoreboard bits cleared.
  - Round-robin pointer = NUM_REQ-1, so requester 0 has first priority.

Arbitration:
- Combinational.
- At most one grant per cycle.
- Grant only to a requester with req_valid=1.
- Handshake: a transfer occurs when req_valid[i] && req_ready[i].
- A requester must hold valid, rd and data stable until granted.
- The register file always accepts, so there is no backpressure from the output stage; one grant is possible every cycle.

Output stage:
- A transfer accepted at edge N drives rf_write_enable=1, rf_write_reg=rd, rf_write_data=data during cycle N+1 (latency 1).
- A cycle with no transfer drives rf_write_enable=0 next cycle; reg/data hold their previous values.
- A transfer with rd=0 is accepted (req_ready=1) but produces rf_write_enable=0.

Scoreboard:
- pending[31:1]; pending[0] is constant 0.
- Set: on edge with issue_valid && issue_ready && issue_rd!=0, pending[issue_rd] <= 1.
- Clear: on the edge of an accepted transfer, pending[rd] <= 0.
- Set and clear of the same register on the same edge: set wins, because the new producer is still outstanding.
- Busy flags: rs1_busy = pending[rs1_addr], rs2_busy = pending[rs2_addr]; both are 0 for x0.
- Busy reflects pending only and carries no combinational bypass from req_*. The register file's internal forwarding covers the N+1 write cycle.
- issue_ready = (issue_rd==0) || !pending[issue_rd]. It does not depend on issue_valid.
- Reset asserted mid-operation: the output write is dropped immediately (rf_write_enable=0), and all pending bits clear.

Optional Feature:
Macro ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration.
  - Search starts at pointer+1 mod NUM_REQ and wraps.
  - The pointer updates to the granted index only on a transfer.
- Undefined: fixed priority, lowest index wins.
  - The pointer is not implemented.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> rf_write_enable=0 at once; rs1_busy=rs2_busy=0 for all addresses; issue_ready=1.
- Single write: req_valid=3'b010, rd=5, data=0xDEADBEEF -> req_ready=3'b010 the same cycle; next cycle rf_write_enable=1, rf_write_reg=5, rf_write_data=0xDEADBEEF; the cycle after, rf_write_enable=0.
- Contention, ARB_ROUND_ROBIN_EN defined: req_valid=3'b111 held for 3 cycles -> grant order 0,1,2.
- Contention, ARB_ROUND_ROBIN_EN undefined: req_valid=3'b111 held -> grant order 0,0,0.
- Scoreboard RAW/WAW: issue rd=7 -> next cycle rs1_addr=7 gives rs1_busy=1 and issue_rd=7 gives issue_ready=0. Writeback rd=7 is accepted at edge N -> in cycle N+1 rs1_busy=0 and rf_write_enable=1 with reg=7.
- x0 and collision: issue rd=0 -> no pending bit set. Issue rd=9 on the same edge a writeback of rd=9 is accepted -> pending[9] stays 1. A requester with rd=0 is granted -> rf_write_enable=0.

Source files
------------

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between NUM_REQ writeback
//   sources, keeps a scoreboard of destination registers that still have an
//   in-flight producer, and gives decode RAW busy flags and a WAW issue stall.
//
//   Handshake: requester i transfers on a rising edge where
//   req_valid[i] && req_ready[i]. A requester holds valid, rd and data
//   stable until granted. The register file never back-pressures, so a
//   grant is possible every cycle and req_ready is purely combinational.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   -> round-robin arbitration, search starts after the last
//                  granted index and wraps
//     undefined -> fixed priority, lowest index wins, no pointer state
module regfile_write_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32,
   parameter int PTR_W   = 3
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [5*NUM_REQ-1:0]    req_rd,
   input  logic [XLEN*NUM_REQ-1:0] req_data,
   input  logic                    issue_valid,
   input  logic [4:0]              issue_rd,
   output logic                    issue_ready,
   input  logic [4:0]              rs1_addr,
   input  logic [4:0]              rs2_addr,
   output logic                    rs1_busy,
   output logic                    rs2_busy,
   output logic                    rf_write_enable,
   output logic [4:0]              rf_write_reg,
   output logic [XLEN-1:0]         rf_write_data
);

   // Reject parameter sets the pointer or the grant vector cannot represent.
   if ((NUM_REQ < 2) || (NUM_REQ > 8) || ((2 ** PTR_W) < NUM_REQ)) begin : g_param_check
      $error("regfile_write_arbiter: NUM_REQ must be 2..8 and fit in PTR_W bits");
   end

   logic            grant_found;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_data;
   logic [31:1]     pending_q;
   logic [31:1]     pending_d;
   logic [31:0]     pending_vec;
   logic            do_write;
   logic            do_set;

`ifdef ARB_ROUND_ROBIN_EN
   logic [PTR_W-1:0] rr_ptr;
   logic [PTR_W-1:0] grant_idx;

   // Round-robin grant: first look above the pointer, then wrap to the bottom.
   always_comb begin
      req_ready   = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      sel_rd      = '0;
      sel_data    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (PTR_W'(i) > rr_ptr)) begin
            grant_found  = 1'b1;
            req_ready[i] = 1'b1;
            grant_idx    = PTR_W'(i);
            sel_rd       = req_rd[5*i +: 5];
            sel_data     = req_data[XLEN*i +: XLEN];
         end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i] && (PTR_W'(i) <= rr_ptr)) begin
            grant_found  = 1'b1;
            req_ready[i] = 1'b1;
            grant_idx    = PTR_W'(i);
            sel_rd       = req_rd[5*i +: 5];
            sel_data     = req_data[XLEN*i +: XLEN];
         end
      end
   end

   // Pointer remembers the last granted requester; it moves only on a transfer.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr <= PTR_W'(NUM_REQ - 1);
      end else if (grant_found) begin
         rr_ptr <= grant_idx;
      end
   end
`else
   // Fixed-priority grant: lowest valid index wins.
   always_comb begin
      req_ready   = '0;
      grant_found = 1'b0;
      sel_rd      = '0;
      sel_data    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!grant_found && req_valid[i]) begin
            grant_found  = 1'b1;
            req_ready[i] = 1'b1;
            sel_rd       = req_rd[5*i +: 5];
            sel_data     = req_data[XLEN*i +: XLEN];
         end
      end
   end
`endif

   // A transfer to x0 is accepted but never reaches the register file.
   assign do_write = grant_found && (sel_rd != 5'd0);

   // Registered write port; reg/data hold their last written values when idle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rf_write_enable <= 1'b0;
         rf_write_reg    <= '0;
         rf_write_data   <= '0;
      end else begin
         rf_write_enable <= do_write;
         if (do_write) begin
            rf_write_reg  <= sel_rd;
            rf_write_data <= sel_data;
         end
      end
   end

   // Scoreboard view with x0 hard-wired to "never pending".
   assign pending_vec = {pending_q, 1'b0};
   assign rs1_busy    = pending_vec[rs1_addr];
   assign rs2_busy    = pending_vec[rs2_addr];
   assign issue_ready = (issue_rd == 5'd0) || !pending_vec[issue_rd];
   assign do_set      = issue_valid && issue_ready && (issue_rd != 5'd0);

   // Next scoreboard: clear the retiring rd first so a same-edge issue wins.
   always_comb begin
      pending_d = pending_q;
      if (do_write) begin
         pending_d[sel_rd] = 1'b0;
      end
      if (do_set) begin
         pending_d[issue_rd] = 1'b1;
      end
   end

   // Scoreboard register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
//   Directed sequence plus a short random phase. A small reference model
//   (grant choice, scoreboard bits, write-port contents) predicts each
//   cycle; the predicted write-port value is queued when the stimulus is
//   applied and popped after the following rising edge.
module tb_regfile_write_arbiter;

   localparam int NUM_REQ = 3;
   localparam int XLEN    = 32;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [NUM_REQ-1:0]      req_valid;
   logic [NUM_REQ-1:0]      req_ready;
   logic [5*NUM_REQ-1:0]    req_rd;
   logic [XLEN*NUM_REQ-1:0] req_data;
   logic                    issue_valid;
   logic [4:0]              issue_rd;
   logic                    issue_ready;
   logic [4:0]              rs1_addr;
   logic [4:0]              rs2_addr;
   logic                    rs1_busy;
   logic                    rs2_busy;
   logic                    rf_write_enable;
   logic [4:0]              rf_write_reg;
   logic [XLEN-1:0]         rf_write_data;

   regfile_write_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .PTR_W(3)) dut (
      .clk             (clk),
      .reset           (reset),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_rd          (req_rd),
      .req_data        (req_data),
      .issue_valid     (issue_valid),
      .issue_rd        (issue_rd),
      .issue_ready     (issue_ready),
      .rs1_addr        (rs1_addr),
      .rs2_addr        (rs2_addr),
      .rs1_busy        (rs1_busy),
      .rs2_busy        (rs2_busy),
      .rf_write_enable (rf_write_enable),
      .rf_write_reg    (rf_write_reg),
      .rf_write_data   (rf_write_data)
   );

   // ---------------- scoreboard / model state ----------------
   int          n_vec = 0;
   int          n_err = 0;
   logic [37:0] exp_q[$];
   logic [31:0] m_pend;
   int          m_ptr;
   logic [4:0]  m_reg;
   logic [31:0] m_data;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_pend = '0;
      m_ptr  = NUM_REQ - 1;
      m_reg  = '0;
      m_data = '0;
   endtask

   // Index the arbiter should grant, or -1 when nothing is valid.
   function automatic int model_grant(input logic [2:0] v, input int ptr);
      int idx;
`ifdef ARB_ROUND_ROBIN_EN
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (ptr + k) % NUM_REQ;
         if (v[2'(idx)]) return idx;
      end
`else
      for (int i = 0; i < NUM_REQ; i++) begin
         idx = i + ptr - ptr;
         if (v[2'(idx)]) return idx;
      end
`endif
      return -1;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic set_req(input int i, input logic v, input logic [4:0] rd, input logic [31:0] d);
      logic [2:0]  vm;
      logic [14:0] rm;
      logic [95:0] dm;
      vm = 3'(1 << i);
      rm = 15'h1f << (i * 5);
      dm = {64'b0, 32'hffff_ffff} << (i * 32);
      req_valid = v ? (req_valid | vm) : (req_valid & ~vm);
      req_rd    = (req_rd & ~rm) | (15'(rd) << (i * 5));
      req_data  = (req_data & ~dm) | (96'(d) << (i * 32));
   endtask

   // One clock: check combinational outputs mid-cycle, update the model,
   // queue the expected write port, then pop and compare after the edge.
   task automatic tick(output int gidx);
      logic [2:0]  g;
      logic [4:0]  rd;
      logic        en;
      logic        ir;
      logic [37:0] e;
      @(negedge clk);
      gidx = model_grant(req_valid, m_ptr);
      g = (gidx >= 0) ? 3'(1 << gidx) : 3'b000;
      check("req_ready", req_ready, g);
      ir = (issue_rd == 5'd0) || !m_pend[issue_rd];
      check("issue_ready", issue_ready, ir);
      check("rs1_busy", rs1_busy, m_pend[rs1_addr]);
      check("rs2_busy", rs2_busy, m_pend[rs2_addr]);
      en = 1'b0;
      if (gidx >= 0) begin
         rd = 5'(req_rd >> (gidx * 5));
         if (rd != 5'd0) begin
            en     = 1'b1;
            m_reg  = rd;
            m_data = 32'(req_data >> (gidx * 32));
         end
         m_pend[rd] = 1'b0;
         m_ptr = gidx;
      end
      if (issue_valid && ir && (issue_rd != 5'd0)) m_pend[issue_rd] = 1'b1;
      m_pend[0] = 1'b0;
      exp_q.push_back({en, m_reg, m_data});
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      check("rf_write_enable", rf_write_enable, e[37]);
      check("rf_write_reg", rf_write_reg, e[36:32]);
      check("rf_write_data", rf_write_data, e[31:0]);
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int g;
      int order[3];
      req_valid   = '0;
      req_rd      = '0;
      req_data    = '0;
      issue_valid = 1'b0;
      issue_rd    = '0;
      rs1_addr    = '0;
      rs2_addr    = '0;
      model_reset();

      // Reset values
      #1 reset = 1'b1;
      #1;
      check("reset_we", rf_write_enable, 1'b0);
      check("reset_reg", rf_write_reg, 5'd0);
      check("reset_data", rf_write_data, 32'd0);
      check("reset_issue_ready", issue_ready, 1'b1);
      @(posedge clk);
      #1 reset = 1'b0;

      // Single write from requester 1
      set_req(1, 1'b1, 5'd5, 32'hDEAD_BEEF);
      tick(g);
      check("single_we", rf_write_enable, 1'b1);
      check("single_reg", rf_write_reg, 5'd5);
      check("single_data", rf_write_data, 32'hDEAD_BEEF);
      set_req(1, 1'b0, 5'd0, 32'd0);
      tick(g);
      check("single_we_drop", rf_write_enable, 1'b0);
      check("single_reg_hold", rf_write_reg, 5'd5);

      // Contention: all three held for three cycles
`ifdef ARB_ROUND_ROBIN_EN
      order = '{0, 1, 2};
`else
      order = '{0, 0, 0};
`endif
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(i + 1), 32'hAAAA_0000 + i);
      for (int k = 0; k < 3; k++) begin
         tick(g);
         check("contention_order", rf_write_reg, 5'(order[k] + 1));
      end
      for (int k = 0; k < 8; k++) begin
         if (req_valid == 3'b000) break;
         tick(g);
         if (g >= 0) set_req(g, 1'b0, 5'd0, 32'd0);
      end

      // RAW / WAW on x7
      issue_valid = 1'b1;
      issue_rd    = 5'd7;
      rs1_addr    = 5'd7;
      tick(g);
      issue_valid = 1'b0;
      #1;
      check("raw_busy_set", rs1_busy, 1'b1);
      check("waw_stall", issue_ready, 1'b0);
      set_req(2, 1'b1, 5'd7, 32'h0000_7777);
      tick(g);
      check("raw_busy_clear", rs1_busy, 1'b0);
      check("wb7_we", rf_write_enable, 1'b1);
      check("wb7_reg", rf_write_reg, 5'd7);
      set_req(2, 1'b0, 5'd0, 32'd0);

      // Issue to x0 sets nothing
      issue_valid = 1'b1;
      issue_rd    = 5'd0;
      rs1_addr    = 5'd0;
      tick(g);
      check("x0_issue_ready", issue_ready, 1'b1);
      check("x0_busy", rs1_busy, 1'b0);

      // Same-edge issue and writeback of x9: set wins
      issue_rd = 5'd9;
      rs2_addr = 5'd9;
      set_req(0, 1'b1, 5'd9, 32'h0000_9999);
      tick(g);
      issue_valid = 1'b0;
      #1;
      check("collision_busy", rs2_busy, 1'b1);
      check("collision_stall", issue_ready, 1'b0);
      tick(g);
      check("collision_retire", rs2_busy, 1'b0);
      set_req(0, 1'b0, 5'd0, 32'd0);

      // Writeback to x0 is accepted but not written
      set_req(1, 1'b1, 5'd0, 32'h1234_5678);
      tick(g);
      check("x0_wb_we", rf_write_enable, 1'b0);
      set_req(1, 1'b0, 5'd0, 32'd0);

      // Random traffic obeying the hold-until-granted rule
      for (int k = 0; k < 24; k++) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!req_valid[2'(i)] && ($urandom_range(0, 1) == 1))
               set_req(i, 1'b1, 5'($urandom_range(0, 31)), $urandom);
         end
         issue_valid = 1'($urandom_range(0, 1));
         issue_rd    = 5'($urandom_range(0, 31));
         rs1_addr    = 5'($urandom_range(0, 31));
         rs2_addr    = 5'($urandom_range(0, 31));
         tick(g);
         if (g >= 0) set_req(g, 1'b0, 5'd0, 32'd0);
      end
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
      issue_valid = 1'b0;

      // Asynchronous reset mid-operation
      issue_valid = 1'b1;
      issue_rd    = 5'd12;
      set_req(0, 1'b1, 5'd3, 32'h0000_3333);
      tick(g);
      issue_valid = 1'b0;
      set_req(0, 1'b0, 5'd0, 32'd0);
      check("pre_reset_we", rf_write_enable, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("async_reset_we", rf_write_enable, 1'b0);
      check("async_reset_reg", rf_write_reg, 5'd0);
      for (int a = 0; a < 32; a++) begin
         rs1_addr = 5'(a);
         rs2_addr = 5'(31 - a);
         #1;
         check("reset_rs1_busy", rs1_busy, 1'b0);
         check("reset_rs2_busy", rs2_busy, 1'b0);
      end
      issue_rd = 5'd12;
      #1;
      check("reset_issue_ready_12", issue_ready, 1'b1);
      model_reset();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Pointer restarts so requester 0 wins first
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 5'(21 + i), 32'hBBBB_0000 + i);
      tick(g);
      check("post_reset_first_grant", rf_write_reg, 5'd21);
      for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 5'd0, 32'd0);
      tick(g);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
